// File: rtl/tail_light_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : tail_light_input_conditioner_if
// Description : Raw switch inputs and conditioned request/tick outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface tail_light_input_conditioner_if;
    logic [1:0] SW;
    logic       HAZ_KEY_N;
    logic       left_q;
    logic       right_q;
    logic       haz_q;
    logic       chg;
    logic       tick;

    modport master (
        output SW,
        output HAZ_KEY_N,
        input  left_q,
        input  right_q,
        input  haz_q,
        input  chg,
        input  tick
    );

    modport slave (
        input  SW,
        input  HAZ_KEY_N,
        output left_q,
        output right_q,
        output haz_q,
        output chg,
        output tick
    );
endinterface
`default_nettype wire

// File: rtl/tail_light_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tail_light_input_conditioner
// Description : Sync, debounce and resolve turn/hazard inputs; step tick gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tail_light_input_conditioner #(
    parameter int DB_CYCLES = 500000,
    parameter int TICK_DIV  = 2500000
) (
    input  wire logic                 ADC_CLK_10,
    input  wire logic                 RST_N,
    tail_light_input_conditioner_if.slave bus
);

    localparam int c_DB_W   = $clog2(DB_CYCLES + 1);
    localparam int c_TICK_W = $clog2(TICK_DIV);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    // Bit order {hazard_n, left, right}; idle means no switch and key released.
    localparam logic [2:0]          c_RAW_IDLE  = 3'b100;

    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_sync;
    logic [2:0] w_stab;

    assign w_raw = {bus.HAZ_KEY_N, bus.SW[1], bus.SW[0]};

    always_ff @(posedge ADC_CLK_10 or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= c_RAW_IDLE;
            r_sync2 <= c_RAW_IDLE;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sync = {~r_sync2[2], r_sync2[1:0]};

    for (genvar gi = 0; gi < 3; gi++) begin : g_db
        logic [c_DB_W-1:0] r_cnt;
        logic              r_stab;

        always_ff @(posedge ADC_CLK_10 or negedge RST_N) begin
            if (!RST_N) begin
                r_cnt  <= '0;
                r_stab <= 1'b0;
            end else if (w_sync[gi] == r_stab) begin
                r_cnt  <= '0;
            end else if (r_cnt == c_DB_LAST) begin
                r_stab <= w_sync[gi];
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end

        assign w_stab[gi] = r_stab;
    end

    logic w_haz;
    logic w_left;
    logic w_right;
    logic w_chg;
    logic r_haz;
    logic r_left;
    logic r_right;
    logic r_chg;

    // Left and right together is treated as a hazard request.
    assign w_haz   = w_stab[2] | (w_stab[1] & w_stab[0]);
    assign w_left  = w_stab[1] & ~w_haz;
    assign w_right = w_stab[0] & ~w_haz;
    assign w_chg   = (w_haz != r_haz) | (w_left != r_left) | (w_right != r_right);

    always_ff @(posedge ADC_CLK_10 or negedge RST_N) begin
        if (!RST_N) begin
            r_haz   <= 1'b0;
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_chg   <= 1'b0;
        end else begin
            r_haz   <= w_haz;
            r_left  <= w_left;
            r_right <= w_right;
            r_chg   <= w_chg;
        end
    end

    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    // A request change restarts the period so the sequencer sees a full step.
    always_ff @(posedge ADC_CLK_10 or negedge RST_N) begin
        if (!RST_N) begin
            r_tick_cnt <= '0;
        end else if (r_chg || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign bus.left_q  = r_left;
    assign bus.right_q = r_right;
    assign bus.haz_q   = r_haz;
    assign bus.chg     = r_chg;
    assign bus.tick    = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_tail_light_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_tail_light_input_conditioner
// Description : Directed plus random stimulus against a history-window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tail_light_input_conditioner;

    localparam int DB = 4;
    localparam int TD = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tail_light_input_conditioner_if bus();

    tail_light_input_conditioner #(
        .DB_CYCLES (DB),
        .TICK_DIV  (TD)
    ) dut (
        .ADC_CLK_10 (clk),
        .RST_N      (rst_n),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    // Raw input history, [0] = most recent sample; stable levels; expected outputs.
    bit [DB:0] hl, hr, hh;
    bit        sl, sr, sh;
    bit        el, er, eh, ec;
    int        phase;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hl = '0; hr = '0; hh = '0;
        sl = 0; sr = 0; sh = 0;
        el = 0; er = 0; eh = 0; ec = 0;
        phase = 0;
    endtask

    task automatic model_edge(input bit rl, input bit rr, input bit rh);
        bit nl, nr, nh;
        phase = ec ? 0 : phase + 1;
        nh = sh | (sl & sr);
        nl = sl & ~nh;
        nr = sr & ~nh;
        ec = ({nl, nr, nh} != {el, er, eh});
        el = nl; er = nr; eh = nh;
        // A level is accepted after DB consecutive synchronised samples of it.
        if (hl[DB:1] == {DB{~sl}}) sl = ~sl;
        if (hr[DB:1] == {DB{~sr}}) sr = ~sr;
        if (hh[DB:1] == {DB{~sh}}) sh = ~sh;
        hl = {hl[DB-1:0], rl};
        hr = {hr[DB-1:0], rr};
        hh = {hh[DB-1:0], rh};
    endtask

    task automatic check_all();
        chk("left_q",  bus.left_q,  el);
        chk("right_q", bus.right_q, er);
        chk("haz_q",   bus.haz_q,   eh);
        chk("chg",     bus.chg,     ec);
        chk("tick",    bus.tick,    (phase % TD) == TD - 1);
    endtask

    task automatic cycle();
        bit   rl, rr, rh;
        logic rs;
        rl = bus.SW[1];
        rr = bus.SW[0];
        rh = ~bus.HAZ_KEY_N;
        rs = rst_n;
        @(posedge clk);
        if (!rs) model_reset();
        else     model_edge(rl, rr, rh);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset_check();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_left",  bus.left_q,  1'b0);
        chk("async_right", bus.right_q, 1'b0);
        chk("async_haz",   bus.haz_q,   1'b0);
        chk("async_tick",  bus.tick,    1'b0);
    endtask

    initial begin
        int n;
        int ticks[$];
        int chg_seen;

        bus.SW        = 2'b00;
        bus.HAZ_KEY_N = 1'b1;
        model_reset();

        // Reset held, then tick cadence from release
        repeat (5) cycle();
        rst_n = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            cycle();
            if (bus.tick) ticks.push_back(i);
        end
        chk_int("tick_count", ticks.size(), 3);
        if (ticks.size() == 3) begin
            chk_int("tick_first",  ticks[0], 7);
            chk_int("tick_second", ticks[1], 15);
            chk_int("tick_third",  ticks[2], 23);
        end

        // Three-cycle glitch on the left switch is rejected
        chg_seen = 0;
        bus.SW = 2'b10;
        repeat (3) cycle();
        bus.SW = 2'b00;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (bus.chg) chg_seen++;
        end
        chk_int("glitch_chg", chg_seen, 0);
        chk("glitch_left", bus.left_q, 1'b0);

        // Left request latency and tick restart
        bus.SW = 2'b10;
        n = 0;
        while (!bus.left_q && n < 20) begin cycle(); n++; end
        chk_int("left_latency", n, 7);
        chk("left_chg", bus.chg, 1'b1);
        n = 0;
        do begin cycle(); n++; end while (!bus.tick && n < 20);
        chk_int("left_next_tick", n, 8);

        // Hazard overrides left, then releases
        bus.HAZ_KEY_N = 1'b0;
        n = 0;
        while (!bus.haz_q && n < 20) begin cycle(); n++; end
        chk_int("haz_latency", n, 7);
        chk("haz_left_off", bus.left_q, 1'b0);
        chk("haz_chg", bus.chg, 1'b1);
        bus.HAZ_KEY_N = 1'b1;
        n = 0;
        while (bus.haz_q && n < 20) begin cycle(); n++; end
        chk_int("haz_rel_latency", n, 7);
        chk("haz_rel_left", bus.left_q, 1'b1);
        repeat (10) cycle();

        // Both switches act as hazard; chg lands on terminal count
        n = 0;
        while ((phase % TD) != 0 && n < 20) begin cycle(); n++; end
        bus.SW = 2'b11;
        repeat (7) cycle();
        chk("both_haz",   bus.haz_q,   1'b1);
        chk("both_left",  bus.left_q,  1'b0);
        chk("both_right", bus.right_q, 1'b0);
        chk("both_chg",   bus.chg,     1'b1);
        chk("both_tick",  bus.tick,    1'b1);
        n = 0;
        do begin cycle(); n++; end while (!bus.tick && n < 20);
        chk_int("both_next_tick", n, 8);

        // Reset mid-debounce and mid-period, input held active through it
        bus.SW = 2'b01;
        repeat (3) cycle();
        async_reset_check();
        repeat (3) cycle();
        rst_n = 1'b1;
        n = 0;
        while (!bus.right_q && n < 20) begin cycle(); n++; end
        chk_int("rst_right_latency", n, 7);
        chk("rst_first_tick", bus.tick, 1'b1);

        // Random stimulus with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                bus.SW        = 2'($urandom_range(0, 3));
                bus.HAZ_KEY_N = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 299) == 0) begin
                async_reset_check();
                repeat (2) cycle();
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tail_light_input_conditioner.md
Name: tail_light_input_conditioner

Overview:
- Front-end stage directly upstream of the Thunderbird tail-light sequencer FSM.
- Synchronises and debounces the left/right turn switches and the hazard push-button.
- Resolves conflicting requests and produces clean request levels, a one-cycle change pulse, and the sequencer's step tick (clock enable), so the FSM runs on ADC_CLK_10 with no divider of its own.

Parameters:
- DB_CYCLES, 500000: consecutive stable cycles required to accept a new input level (50 ms at 10 MHz); must be >= 1.
- TICK_DIV, 2500000: ADC_CLK_10 cycles per sequencer step (4 Hz); must be >= 2.

Ports:
- ADC_CLK_10  input   1   system clock, 10 MHz.
- RST_N       input   1   asynchronous active-low reset, driven from KEY[0].
- SW          input   2   raw switches: SW[0] right turn, SW[1] left turn; active-high.
- HAZ_KEY_N   input   1   raw hazard push-button from KEY[1]; active-low.
- left_q      output  1   debounced, resolved left-turn request.
- right_q     output  1   debounced, resolved right-turn request.
- haz_q       output  1   debounced, resolved hazard request.
- chg         output  1   one-cycle pulse when any of left_q/right_q/haz_q changes.
- tick        output  1   one-cycle step enable for the sequencer.

Behaviour:
- Reset (async assert, sync release on ADC_CLK_10):
  - All outputs 0.
  - Sync flops at inactive values: SW=0, HAZ_KEY_N=1.
  - Stable registers hold inactive levels; debounce and tick counters 0.
- Synchronisers:
  - Each of the 3 inputs passes through a 2-flop synchroniser.
  - HAZ_KEY_N is inverted after synchronisation, giving active-high h_s.
- Debounce, independent per channel, counter width $clog2(DB_CYCLES+1):
  - Synced value equal to the channel's stable value: counter cleared.
  - Synced value different: counter increments each cycle.
  - When the counter reaches DB_CYCLES-1 while still different, the stable value takes the synced value on that edge and the counter clears.
  - Latency from a raw input edge to the stable register: 2 + DB_CYCLES cycles. A glitch shorter than DB_CYCLES cycles (after sync) never changes the stable value.
- Resolution (registered, one cycle after the stable registers):
  - haz_q = h_stab OR (l_stab AND r_stab).
  - left_q = l_stab AND NOT haz_q.
  - right_q = r_stab AND NOT haz_q.
  - Hazard always dominates; left+right together acts as hazard.
  - Total input-to-output latency: 3 + DB_CYCLES cycles.
- chg:
  - High for exactly one cycle, in the same cycle the new resolved outputs first appear.
  - Multiple channels changing on the same edge produce one pulse.
- Tick generator, counter width $clog2(TICK_DIV):
  - Free-running 0..TICK_DIV-1; tick=1 in the cycle the count equals TICK_DIV-1; the count then wraps to 0.
  - Period TICK_DIV cycles; first tick after reset release at cycle TICK_DIV-1.
  - Restart: a cycle with chg=1 loads the count with 0, so the sequencer gets a full period after every request change.
  - chg=1 coinciding with terminal count: tick still asserts in that cycle and the count goes to 0. No tick is lost or doubled.
- Reset mid-debounce or mid-period: everything returns to reset values immediately. Inputs held active through reset are re-qualified from scratch, taking full latency after release.
- No combinational path from any input to any output.

Test Plan (bench overrides DB_CYCLES=4, TICK_DIV=8):
1. Hold RST_N=0 for 5 cycles, then release with SW=0 and HAZ_KEY_N=1.
   - All outputs 0 throughout reset.
   - tick pulses at cycles 7, 15, 23 after release, each exactly 1 cycle wide.
2. SW=2'b10 (left) held.
   - left_q rises exactly 7 cycles after the SW edge, with a one-cycle chg in the same cycle.
   - The next tick comes 8 cycles later.
3. SW[1] glitches high for 3 cycles, then returns low.
   - left_q, chg and tick phase are all unchanged.
4. With left_q=1, drive HAZ_KEY_N=0.
   - After 7 cycles haz_q=1 and left_q=0 in the same cycle, with a single chg pulse.
   - Release HAZ_KEY_N: after 7 cycles haz_q=0 and left_q=1.
5. SW=2'b11.
   - haz_q=1, left_q=0, right_q=0.
   - SW change timed so chg lands on a terminal count: exactly one tick that cycle, next tick 8 cycles later.
6. Assert RST_N=0 during the debounce of a SW change and during a tick period.
   - Outputs clear asynchronously, without waiting for a clock edge.
   - After release with SW still active, the output appears 7 cycles later and the first tick comes at cycle 7.
